register_file_mp: RTL and testbench

Parametrised multi-port general-purpose register file for the pipelined and multicore datapaths. It supports configurable word width, register count and read-port count, and has two write ports, which lets the writeback stage retire two results per cycle. It also provides a sequential bulk-clear engine for context reset. An optional same-cycle write-to-read bypass is selected at compile time. Register 0 is hardwired to zero.

---
 rtl/register_file_mp.sv | 78 +++++++
 tb/tb_register_file_mp.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Multi-port register file: NREAD combinational reads, two write ports, and a sequential bulk-clear engine.
// Compile-time option REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module register_file_mp #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter int SELW  = $clog2(NREGS)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [1:0]                  WEN,
  input  logic [1:0][SELW-1:0]        wsel,
  input  logic [1:0][WIDTH-1:0]       wdat,
  input  logic [NREAD-1:0][SELW-1:0]  rsel,
  output logic [NREAD-1:0][WIDTH-1:0] rdat,
  input  logic                        clr_req,
  output logic                        busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [SELW-1:0]  cnt;
  logic [WIDTH-1:0] regs [1:NREGS-1];
  logic [WIDTH-1:0] view [NREGS];

  // Port 1 is applied last so it wins a same-register collision; clearing blocks all writes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 1; i < NREGS; i++) regs[i] <= '0;
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          for (int p = 0; p < 2; p++) begin
            if (WEN[p] && wsel[p] != '0) regs[wsel[p]] <= wdat[p];
          end
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= SELW'(1);
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          regs[cnt] <= '0;
          if (cnt == SELW'(NREGS - 1)) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + SELW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register 0 has no storage; it is a constant zero in the read view.
  always_comb begin
    view[0] = '0;
    for (int i = 1; i < NREGS; i++) view[i] = regs[i];
  end

  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      rdat[i] = view[rsel[i]];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < 2; p++) begin
        if (WEN[p] && wsel[p] == rsel[i] && wsel[p] != '0 && state == IDLE) rdat[i] = wdat[p];
      end
`endif
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp (WIDTH=32, NREGS=32, NREAD=4), valid with or without REGFILE_BYPASS_EN.
module tb_register_file_mp;

  logic             CLK;
  logic             RST;
  logic [1:0]       WEN;
  logic [1:0][4:0]  wsel;
  logic [1:0][31:0] wdat;
  logic [3:0][4:0]  rsel;
  logic [3:0][31:0] rdat;
  logic             clr_req;
  logic             busy;

  int numCompared;
  int numMismatched;

  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  ws0;
    logic [31:0] wd0;
    logic [4:0]  ws1;
    logic [31:0] wd1;
    logic [4:0]  rs;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs [8];

  register_file_mp #(.WIDTH(32), .NREGS(32), .NREAD(4)) dut (
    .CLK(CLK), .RST(RST), .WEN(WEN), .wsel(wsel), .wdat(wdat),
    .rsel(rsel), .rdat(rdat), .clr_req(clr_req), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] wen, input logic [4:0] ws0, input logic [31:0] wd0,
                               input logic [4:0] ws1, input logic [31:0] wd1);
    WEN     = wen;
    wsel[0] = ws0;
    wdat[0] = wd0;
    wsel[1] = ws1;
    wdat[1] = wd1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    numCompared++;
    if (act !== expv) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic readAll(input logic [4:0] r);
    for (int i = 0; i < 4; i++) rsel[i] = r;
    #1;
  endtask

  initial begin
    int n;
    int firstLen;
    numCompared   = 0;
    numMismatched = 0;
    RST     = 1'b1;
    clr_req = 1'b0;
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    rsel = '0;

    // Reset state.
    #2;
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    rsel[0] = 5'd1; rsel[1] = 5'd7; rsel[2] = 5'd31; rsel[3] = 5'd0;
    #1;
    for (int i = 0; i < 4; i++) checkOutput($sformatf("reset_rdat%0d", i), rdat[i], 32'h0);
    #5;
    RST = 1'b0;
    tick();

    vecs[0] = '{2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,        5'd5,  32'hDEADBEEF};
    vecs[1] = '{2'b11, 5'd7,  32'h11111111, 5'd7,  32'h22222222, 5'd7,  32'h22222222};
    vecs[2] = '{2'b11, 5'd3,  32'hA,        5'd4,  32'hB,        5'd3,  32'hA};
    vecs[3] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd4,  32'hB};
    vecs[4] = '{2'b11, 5'd0,  32'hFFFFFFFF, 5'd0,  32'hFFFFFFFF, 5'd0,  32'h0};
    vecs[5] = '{2'b10, 5'd0,  32'h0,        5'd12, 32'hCAFE,     5'd12, 32'hCAFE};
    vecs[6] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd5,  32'hDEADBEEF};
    vecs[7] = '{2'b01, 5'd5,  32'h55,       5'd9,  32'h99,       5'd5,  32'h55};

    // Each vector writes at one edge, then reads back on all ports in the next cycle.
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].wen, vecs[v].ws0, vecs[v].wd0, vecs[v].ws1, vecs[v].wd1);
      tick();
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      readAll(vecs[v].rs);
      for (int i = 0; i < 4; i++) checkOutput($sformatf("vec%0d_port%0d", v, i), rdat[i], vecs[v].expData);
    end

    // Register 0 write in the same cycle as the read must still read zero.
    applyStimulus(2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF);
    readAll(5'd0);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("r0_samecycle_port%0d", i), rdat[i], 32'h0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

    // Bypass: r9 holds 1, then 0x12345678 is written while port 2 reads r9.
    applyStimulus(2'b01, 5'd9, 32'h1, 5'd0, 32'h0);
    tick();
    applyStimulus(2'b01, 5'd9, 32'h12345678, 5'd0, 32'h0);
    rsel = '0;
    rsel[2] = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("bypass_samecycle", rdat[2], 32'h12345678);
`else
    checkOutput("bypass_samecycle", rdat[2], 32'h1);
`endif
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #1;
    checkOutput("bypass_nextcycle", rdat[2], 32'h12345678);

    // Reset in the third CLEAR cycle.
    applyStimulus(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    tick();
    rsel[0] = 5'd5; rsel[1] = 5'd7; rsel[2] = 5'd9; rsel[3] = 5'd12;
    #1;
    checkOutput("midclear_busy", {31'b0, busy}, 32'h1);
    checkOutput("midclear_r5", rdat[0], 32'hDEADBEEF);
    RST = 1'b1;
    #1;
    checkOutput("rstclear_busy", {31'b0, busy}, 32'h0);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("rstclear_rdat%0d", i), rdat[i], 32'h0);
    #1;
    RST = 1'b0;
    tick();
    applyStimulus(2'b01, 5'd5, 32'h00C0FFEE, 5'd0, 32'h0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #1;
    checkOutput("postrst_r5", rdat[0], 32'h00C0FFEE);
    checkOutput("postrst_busy", {31'b0, busy}, 32'h0);

    // Fill r1..r31 with i*0x100.
    for (int r = 1; r < 32; r++) begin
      applyStimulus(2'b01, 5'(r), 32'(r) * 32'h100, 5'd0, 32'h0);
      tick();
    end
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    readAll(5'd31);
    checkOutput("fill_r31", rdat[0], 32'h1F00);

    // Clear sequence with writes and a repeated clr_req while busy.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    rsel[0] = 5'd20; rsel[1] = 5'd25; rsel[2] = 5'd31; rsel[3] = 5'd1;
    n = 0;
    while (busy && n < 100) begin
      applyStimulus(2'b11, 5'd20, 32'hBAD0BAD0, 5'd25, 32'hBAD1BAD1);
      clr_req = (n == 4);
      #1;
      if (n == 9) begin
        checkOutput("clear_cycle10_r20", rdat[0], 32'h1400);
        checkOutput("clear_cycle10_r25", rdat[1], 32'h1900);
        checkOutput("clear_cycle10_r1",  rdat[3], 32'h0);
      end
      @(posedge CLK);
      #1;
      n++;
    end
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    clr_req = 1'b0;
    checkOutput("clear_len", 32'(n), 32'd31);
    for (int r = 0; r < 32; r++) begin
      rsel[0] = 5'(r);
      #0.1;
      if (rdat[0] !== 32'h0) checkOutput($sformatf("cleared_r%0d", r), rdat[0], 32'h0);
    end
    readAll(5'd20);
    checkOutput("cleared_r20", rdat[1], 32'h0);
    readAll(5'd25);
    checkOutput("cleared_r25", rdat[2], 32'h0);

    // Back-to-back clears: clr_req raised in the cycle busy falls starts a new sequence.
    tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    firstLen = n;
    checkOutput("seqA_len", 32'(firstLen), 32'd31);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    checkOutput("seqB_started", {31'b0, busy}, 32'h1);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    checkOutput("seqB_len", 32'(n), 32'd31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
